// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared states, port ids and byte-enable constants for the RAM port arbiter
package ram_arb_pkg;
  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;
  typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_t;
  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-input round-robin pointer with combinational grants
module ram_arb_rr import ram_arb_pkg::*; #(
  parameter bit RST_PRIO_DATA = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic req_instr,
  input  logic req_data,
  output logic gnt_instr,
  output logic gnt_data
);
  port_t ptr;
  always_comb begin
    gnt_data  = en && req_data && (!req_instr || ptr == PORT_DATA);
    gnt_instr = en && req_instr && !gnt_data;
  end
  // any grant hands priority to the port that was not served
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ptr <= RST_PRIO_DATA ? PORT_DATA : PORT_INSTR;
    else if (gnt_data) ptr <= PORT_INSTR;
    else if (gnt_instr) ptr <= PORT_DATA;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between fetch and load/store ports,
// merging partial stores via read-modify-write
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter bit RST_PRIO_DATA = 1'b1,
  parameter bit RMW_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_din_o,
  input  logic [31:0] ram_dout_i
);
  state_t      state;
  logic        ig, dg, partial, full_wr, i_pend, d_pend, d_rd;
  logic [31:0] rmw_addr, rmw_wdata, merged;
  logic [3:0]  rmw_be;
  ram_arb_rr #(.RST_PRIO_DATA(RST_PRIO_DATA)) u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .en        (rstn && state == IDLE),
    .req_instr (instr_req_i),
    .req_data  (data_req_i),
    .gnt_instr (ig),
    .gnt_data  (dg)
  );
  always_comb begin
    partial = RMW_EN && data_we_i && data_be_i != BE_FULL && data_be_i != BE_NONE;
    full_wr = data_we_i && data_be_i != BE_NONE && !partial;
    merged  = ram_dout_i;
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = rmw_be[k] ? rmw_wdata[8*k +: 8] : ram_dout_i[8*k +: 8];
    instr_gnt_o    = ig;
    data_gnt_o     = dg;
    ram_we_o       = state == RMW_WR || (dg && full_wr);
    ram_addr_o     = state == RMW_WR ? rmw_addr & WORD_MASK :
                     dg ? data_addr_i & WORD_MASK :
                     ig ? instr_addr_i & WORD_MASK : '0;
    ram_din_o      = state == RMW_WR ? merged : (dg && full_wr) ? data_wdata_i : '0;
    instr_rvalid_o = i_pend;
    instr_rdata_o  = i_pend ? ram_dout_i : '0;
    data_rvalid_o  = d_pend;
    data_rdata_o   = (d_pend && d_rd) ? ram_dout_i : '0;
  end
  // a partial store defers its response until the merged write has been issued
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      d_rd      <= 1'b0;
      rmw_addr  <= '0;
      rmw_wdata <= '0;
      rmw_be    <= BE_NONE;
    end else begin
      state  <= (dg && partial) ? RMW_WR : IDLE;
      i_pend <= ig;
      d_pend <= (dg && !partial) || state == RMW_WR;
      d_rd   <= dg && !data_we_i;
      if (dg && partial) begin
        rmw_addr  <= data_addr_i;
        rmw_wdata <= data_wdata_i;
        rmw_be    <= data_be_i;
      end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of the RAM port arbiter against a RAM model
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o, ram_din_o;
  logic [31:0] ram_dout_i;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  logic [31:0] mem [0:63];
  logic [31:0] refm [0:15];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rstn(rstn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  // registered-read single-port RAM with a bench-only preload path
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (ram_we_o) mem[ram_addr_o[7:2]] <= ram_din_o;
    ram_dout_i <= mem[ram_addr_o[7:2]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = v;
    step;
    pl_en = 1'b0;
  endtask

  task automatic data_drive(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] w);
    data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = w;
  endtask

  task automatic test_reset;
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    data_drive(1'b1, 4'hF, 32'h24, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {instr_gnt_o, data_gnt_o, ram_we_o, instr_rvalid_o, data_rvalid_o});
    end
    checks++;
    if ({ram_addr_o, ram_din_o, instr_rdata_o, data_rdata_o} !== 128'b0) begin
      errors++; $display("FAIL reset_data got addr %h din %h ird %h drd %h want 0", ram_addr_o, ram_din_o, instr_rdata_o, data_rdata_o);
    end
    idle_inputs;
    step;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, ram_we_o} !== 3'b0) begin
      errors++; $display("FAIL reset_release got %b want 000", {instr_rvalid_o, data_rvalid_o, ram_we_o});
    end
    step;
  endtask

  task automatic test_contention;
    logic ed, ei, pd;
    preload(4, 32'h1010_1010);
    preload(8, 32'h2020_2020);
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        instr_req_i = 1'b1; instr_addr_i = 32'h10;
        data_drive(1'b0, 4'h0, 32'h20, 32'h0);
      end else idle_inputs;
      @(negedge clk);
      ed = c < 4 && c % 2 == 0;
      ei = c < 4 && c % 2 == 1;
      checks++;
      if ({instr_gnt_o, data_gnt_o, ram_we_o} !== {ei, ed, 1'b0}) begin
        errors++; $display("FAIL contend_gnt[%0d] got %b want %b", c, {instr_gnt_o, data_gnt_o, ram_we_o}, {ei, ed, 1'b0});
      end
      checks++;
      if (ram_addr_o !== (ed ? 32'h20 : ei ? 32'h10 : 32'h0)) begin
        errors++; $display("FAIL contend_addr[%0d] got %h", c, ram_addr_o);
      end
      if (c > 0) begin
        pd = (c - 1) % 2 == 0;
        checks++;
        if ({instr_rvalid_o, data_rvalid_o} !== {!pd, pd} ||
            instr_rdata_o !== (pd ? 32'h0 : 32'h1010_1010) ||
            data_rdata_o !== (pd ? 32'h2020_2020 : 32'h0)) begin
          errors++; $display("FAIL contend_rsp[%0d] got rv %b ird %h drd %h want rv %b", c,
                             {instr_rvalid_o, data_rvalid_o}, instr_rdata_o, data_rdata_o, {!pd, pd});
        end
      end
      step;
    end
  endtask

  task automatic test_write_read;
    data_drive(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o} !== 3'b011 || ram_addr_o !== 32'h40 || ram_din_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_issue got %b addr %h din %h want 011 40 deadbeef", {instr_gnt_o, data_gnt_o, ram_we_o}, ram_addr_o, ram_din_o);
    end
    step;
    data_drive(1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o} !== 4'b0101 || data_rdata_o !== 32'h0 || ram_din_o !== 32'h0) begin
      errors++; $display("FAIL wr_ack got %b rd %h din %h want 0101 0 0", {instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o}, data_rdata_o, ram_din_o);
    end
    step;
    idle_inputs;
    @(negedge clk);
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_readback got %b %h want 1 deadbeef", data_rvalid_o, data_rdata_o);
    end
    step;
  endtask

  task automatic test_rmw;
    preload(17, 32'h1122_3344);
    data_drive(1'b1, 4'b0101, 32'h44, 32'hAABB_CCDD);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o} !== 3'b010 || ram_addr_o !== 32'h44) begin
      errors++; $display("FAIL rmw_read got %b addr %h want 010 44", {instr_gnt_o, data_gnt_o, ram_we_o}, ram_addr_o);
    end
    step;
    idle_inputs;
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o} !== 4'b0010 || ram_addr_o !== 32'h44 || ram_din_o !== 32'h11BB_33DD) begin
      errors++; $display("FAIL rmw_stall got %b addr %h din %h want 0010 44 11bb33dd",
                         {instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o}, ram_addr_o, ram_din_o);
    end
    step;
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o} !== 4'b1001 || data_rdata_o !== 32'h0 || ram_addr_o !== 32'h10) begin
      errors++; $display("FAIL rmw_ack got %b rd %h addr %h want 1001 0 10", {instr_gnt_o, data_gnt_o, ram_we_o, data_rvalid_o}, data_rdata_o, ram_addr_o);
    end
    step;
    idle_inputs;
    data_drive(1'b0, 4'h0, 32'h44, 32'h0);
    @(negedge clk);
    checks++;
    if ({instr_rvalid_o, data_gnt_o} !== 2'b11 || instr_rdata_o !== 32'h1010_1010) begin
      errors++; $display("FAIL rmw_fetch got %b %h want 11 10101010", {instr_rvalid_o, data_gnt_o}, instr_rdata_o);
    end
    step;
    idle_inputs;
    @(negedge clk);
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h11BB_33DD) begin
      errors++; $display("FAIL rmw_merged got %b %h want 1 11bb33dd", data_rvalid_o, data_rdata_o);
    end
    step;
  endtask

  task automatic test_be_none;
    preload(18, 32'h55AA_55AA);
    data_drive(1'b1, 4'b0000, 32'h48, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o} !== 3'b010 || ram_din_o !== 32'h0) begin
      errors++; $display("FAIL benone_issue got %b din %h want 010 0", {instr_gnt_o, data_gnt_o, ram_we_o}, ram_din_o);
    end
    step;
    data_drive(1'b0, 4'h0, 32'h48, 32'h0);
    @(negedge clk);
    checks++;
    if ({data_gnt_o, data_rvalid_o} !== 2'b11 || data_rdata_o !== 32'h0) begin
      errors++; $display("FAIL benone_ack got %b %h want 11 0", {data_gnt_o, data_rvalid_o}, data_rdata_o);
    end
    step;
    idle_inputs;
    @(negedge clk);
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h55AA_55AA) begin
      errors++; $display("FAIL benone_unchanged got %b %h want 1 55aa55aa", data_rvalid_o, data_rdata_o);
    end
    step;
  endtask

  task automatic test_rmw_reset;
    preload(19, 32'h0102_0304);
    data_drive(1'b1, 4'b0011, 32'h4C, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if ({data_gnt_o, ram_we_o} !== 2'b10) begin
      errors++; $display("FAIL rst_rmw_issue got %b want 10", {data_gnt_o, ram_we_o});
    end
    step;
    idle_inputs;
    #1 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o, ram_we_o, instr_rvalid_o, data_rvalid_o} !== 5'b0 ||
        {ram_addr_o, ram_din_o, instr_rdata_o, data_rdata_o} !== 128'b0) begin
      errors++; $display("FAIL rst_rmw_abort got %b addr %h din %h want all 0",
                         {instr_gnt_o, data_gnt_o, ram_we_o, instr_rvalid_o, data_rvalid_o}, ram_addr_o, ram_din_o);
    end
    step;
    rstn = 1'b1;
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    data_drive(1'b0, 4'h0, 32'h4C, 32'h0);
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL rst_prio got %b want 01", {instr_gnt_o, data_gnt_o});
    end
    step;
    data_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_gnt_o, data_rvalid_o} !== 2'b11 || data_rdata_o !== 32'h0102_0304) begin
      errors++; $display("FAIL rst_nowrite got %b %h want 11 01020304", {instr_gnt_o, data_rvalid_o}, data_rdata_o);
    end
    step;
    idle_inputs;
    @(negedge clk);
    checks++;
    if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h1010_1010) begin
      errors++; $display("FAIL rst_fetch got %b %h want 1 10101010", instr_rvalid_o, instr_rdata_o);
    end
    step;
  endtask

  task automatic test_random;
    logic i_act = 1'b0, d_act = 1'b0, d_we = 1'b0, i_due = 1'b0, d_due1 = 1'b0, d_due2 = 1'b0, stall = 1'b0;
    logic gi, gd, ok;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, i_exp = '0, d_exp = '0;
    logic [3:0] d_be = '0;
    int i_wait = 0, d_wait = 0, grants = 0, idx;
    for (int i = 0; i < 16; i++) begin
      refm[i] = $urandom;
      preload(i, refm[i]);
    end
    for (int cyc = 0; cyc < 5000 && grants < 1000; cyc++) begin
      if (!i_act && $urandom_range(0, 9) < 6) begin
        i_act = 1'b1;
        i_addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      end
      if (!d_act && $urandom_range(0, 9) < 6) begin
        d_act = 1'b1;
        d_addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        d_we = $urandom_range(0, 1) == 1;
        d_be = $urandom_range(0, 3) == 0 ? 4'hF : 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      instr_req_i = i_act; instr_addr_i = i_addr;
      data_req_i = d_act; data_we_i = d_we; data_be_i = d_be; data_addr_i = d_addr; data_wdata_i = d_wdata;
      @(negedge clk);
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {i_due, d_due1} || instr_rdata_o !== (i_due ? i_exp : 32'h0) ||
          data_rdata_o !== (d_due1 ? d_exp : 32'h0)) begin
        errors++; $display("FAIL rnd_rsp[%0d] got rv %b ird %h drd %h want rv %b ird %h drd %h", cyc,
                           {instr_rvalid_o, data_rvalid_o}, instr_rdata_o, data_rdata_o,
                           {i_due, d_due1}, i_due ? i_exp : 32'h0, d_due1 ? d_exp : 32'h0);
      end
      gi = instr_gnt_o;
      gd = data_gnt_o;
      ok = !(gi && gd) && ((gi || gd) == (!stall && (i_act || d_act))) && (!gi || i_act) && (!gd || d_act);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rnd_gnt[%0d] got %b req %b stall %b", cyc, {gi, gd}, {i_act, d_act}, stall);
      end
      checks++;
      if (ram_we_o !== (stall || (gd && d_we && d_be == 4'hF))) begin
        errors++; $display("FAIL rnd_we[%0d] got %b want %b", cyc, ram_we_o, stall || (gd && d_we && d_be == 4'hF));
      end
      if (gi || gd) begin
        checks++;
        if (ram_addr_o !== ((gd ? d_addr : i_addr) & 32'hFFFF_FFFC)) begin
          errors++; $display("FAIL rnd_addr[%0d] got %h want %h", cyc, ram_addr_o, (gd ? d_addr : i_addr) & 32'hFFFF_FFFC);
        end
      end
      i_wait = (i_act && !gi) ? i_wait + 1 : 0;
      d_wait = (d_act && !gd) ? d_wait + 1 : 0;
      checks++;
      if (i_wait > 2 || d_wait > 2) begin
        errors++; $display("FAIL rnd_wait[%0d] got instr %0d data %0d want <=2", cyc, i_wait, d_wait);
      end
      i_due = gi;
      if (gi) i_exp = refm[i_addr[5:2]];
      d_due1 = d_due2;
      d_due2 = 1'b0;
      stall = 1'b0;
      if (gd) begin
        idx = int'(d_addr[5:2]);
        d_exp = 32'h0;
        if (!d_we) begin
          d_due1 = 1'b1; d_exp = refm[idx];
        end else if (d_be == 4'hF) begin
          d_due1 = 1'b1; refm[idx] = d_wdata;
        end else if (d_be == 4'h0) begin
          d_due1 = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) if (d_be[k]) refm[idx][8*k +: 8] = d_wdata[8*k +: 8];
          d_due2 = 1'b1; stall = 1'b1;
        end
      end
      if (gi || gd) grants++;
      if (gi) i_act = 1'b0;
      if (gd) d_act = 1'b0;
      step;
    end
    checks++;
    if (grants < 1000) begin
      errors++; $display("FAIL rnd_budget got %0d grants want 1000", grants);
    end
    idle_inputs;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {i_due, d_due1} || data_rdata_o !== (d_due1 ? d_exp : 32'h0) ||
          instr_rdata_o !== (i_due ? i_exp : 32'h0)) begin
        errors++; $display("FAIL rnd_drain[%0d] got rv %b drd %h want rv %b drd %h", c,
                           {instr_rvalid_o, data_rvalid_o}, data_rdata_o, {i_due, d_due1}, d_due1 ? d_exp : 32'h0);
      end
      i_due = 1'b0; d_due1 = d_due2; d_due2 = 1'b0;
      step;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_contention;
    test_write_read;
    test_rmw;
    test_be_none;
    test_rmw_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
